mdio_slave: RTL
===============

// Module: mdio_slave
// PURPOSE
//  Clause-22 MDIO responder (PHY side), oversampled on the local clk. Decodes frames driven
//  on mdc_i/mdio_i, issues single-cycle write/read strobes to a local 32x16 register space,
//  and drives read data back on mdio_o/mdio_t. Used in PHY models, bridges and loopback benches.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on mdc_i and mdio_i (>=2)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  phy_addr     in   5   PHYAD this instance answers to; sampled per frame
//  mdc_i        in   1   MDC from station (asynchronous)
//  mdio_i       in   1   MDIO pad input (asynchronous)
//  mdio_o       out  1   MDIO drive value
//  mdio_t       out  1   tristate enable, 1 = released
//  reg_addr     out  5   REGAD of current frame
//  reg_wr_data  out  16  write data; valid while reg_wr_en=1
//  reg_wr_en    out  1   one-clk write strobe
//  reg_rd_en    out  1   one-clk read strobe
//  reg_rd_data  in   16  read data; must be valid the clk after reg_rd_en
//  busy         out  1   1 from first ST bit until frame end or abort
//  frame_error  out  1   one-clk pulse on bad ST, bad write TA, or OP=00
// BEHAVIOUR
//  - Reset values: mdio_t=1, mdio_o=1, reg_wr_en=0, reg_rd_en=0, busy=0, frame_error=0,
//    reg_addr=0, reg_wr_data=0, state=IDLE, preamble count=0.
//  - mdc_i and mdio_i are synchronised; "rise" is a one-clk pulse on synchronised MDC 0->1.
//  - mdio_i is sampled only on rise. mdio_o/mdio_t update on the same rise, after the sample.
//    The station samples near MDC fall, so data is stable for half an MDC period.
//  - Clock requirement: MDC high and low phases each >= SYNC_STAGES+2 clk periods.
//  - States and transitions:
//    - IDLE: counts consecutive sampled 1s, saturating at 32; a sampled 0 with count==32
//      -> ST1; a sampled 0 with count<32 clears the count.
//    - ST1: next bit must be 1 -> HDR; otherwise frame_error, -> IDLE.
//    - HDR: shift 12 bits OP[1:0] PHYAD[4:0] REGAD[4:0], MSB first. On the 12th bit:
//      - PHYAD!=phy_addr -> IDLE, silently, no strobes;
//      - OP=00 -> frame_error, -> IDLE;
//      - OP=10 or 11 -> reg_rd_en pulse, reg_addr updated, -> TA_RD;
//      - OP=01 -> reg_addr updated, -> TA_WR.
//    - TA_RD: 1st TA rise latches reg_rd_data into the shift register, drives mdio_t=0
//      and mdio_o=0, -> RD.
//    - RD: each of the next 16 rises drives D15..D0. On the following rise mdio_t=1,
//      -> IDLE. mdio_t stays low for exactly 17 MDC periods.
//    - TA_WR: 2 samples must be 1,0; otherwise frame_error, -> IDLE. Then -> WR.
//    - WR: shift 16 bits; 1 clk after the 16th rise, reg_wr_en pulses with full data, -> IDLE.
//  - Preamble count restarts at 0 after every frame end or abort; each frame needs its own
//    preamble (see CONFIGURATION).
//  - Reset mid-frame: mdio_t returns to 1 on the next clk edge; no strobe issued.
//  - Simultaneous events: rise and rst in the same clk -> rst wins.
//  - reg_wr_en and reg_rd_en are never high together.
// CONFIGURATION
//  - MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
//    - Defined: IDLE accepts ST once count>=1. The preamble may be a single 1, so back-to-back
//      frames with no preamble are accepted provided MDIO idles high for >=1 bit.
//    - Undefined: a full 32-bit preamble is mandatory.
// STRUCTURE
//  - Shared package mdio_pkg:
//    - opcode constants MDIO_OP_ADDR=2'b00, MDIO_OP_WRITE=2'b01, MDIO_OP_READ=2'b10,
//      MDIO_OP_READ_INC=2'b11;
//    - MDIO_ST=2'b01, MDIO_TA_WR=2'b10, MDIO_PREAMBLE_LEN=32.
//  - State encoding stays local to this module.
//  - Sub-module mdio_sync_edge: SYNC_STAGES synchroniser plus rise detect for mdc_i, aligned
//    synchronised mdio_i.
// TESTING
//  - Write, phy_addr=5'h03: PHYAD 03, REGAD 1F, data 16'hA5C3 -> one reg_wr_en pulse,
//    reg_addr=1F, reg_wr_data=A5C3; mdio_t=1 throughout.
//  - Read, reg_rd_data=16'h1234 -> reg_rd_en pulse; station captures TA0 = 0, then
//    data 16'h1234; mdio_t low for 17 MDC periods.
//  - Read to PHYAD 04 with phy_addr=03 -> no strobes, mdio_t=1, frame_error=0; the next
//    frame to 03 succeeds.
//  - Write with TA=11 -> frame_error pulse, no reg_wr_en. ST=00 after preamble ->
//    frame_error pulse. OP=00 -> frame_error pulse.
//  - 8-bit preamble then write:
//    - macro undefined -> ignored;
//    - macro defined -> reg_wr_en pulse.
//  - rst asserted mid-RD -> mdio_t=1 next clk, busy=0; a following full read returns
//    correct data.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO frame constants and the header payload layout.
package mdio_pkg;

    localparam logic [1:0] MDIO_OP_ADDR     = 2'b00;
    localparam logic [1:0] MDIO_OP_WRITE    = 2'b01;
    localparam logic [1:0] MDIO_OP_READ     = 2'b10;
    localparam logic [1:0] MDIO_OP_READ_INC = 2'b11;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int unsigned MDIO_PREAMBLE_LEN = 32;
    localparam int unsigned MDIO_DATA_W       = 16;

    // OP, PHYAD, REGAD as shifted in MSB first
    typedef struct packed {
        logic [1:0] op;
        logic [4:0] phyad;
        logic [4:0] regad;
    } mdio_hdr_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// Synchronises MDC/MDIO onto clk; rise_c pulses one clk per MDC 0->1, mdio_q aligned to it.
module mdio_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic rise_c,
    output logic mdio_q
);

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_sync  <= '0;
            mdio_sync <= '1;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_prev  <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign rise_c = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign mdio_q = mdio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder oversampled on clk, driving a local 32x16 register strobe interface.
// Build option: MDIO_SLAVE_PREAMBLE_SUPPRESS_EN accepts frames after a preamble of a single 1.
module mdio_slave
    import mdio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  phy_addr,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        frame_error
);

    localparam int unsigned PRE_CNT_W = 6;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned HDR_LAST  = 11;
    localparam int unsigned DATA_LAST = MDIO_DATA_W - 1;
    localparam int unsigned RD_END    = MDIO_DATA_W;
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
    localparam int unsigned PRE_MIN   = 1;
`else
    localparam int unsigned PRE_MIN   = MDIO_PREAMBLE_LEN;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ST1, S_HDR, S_TA_RD, S_RD, S_TA_WR, S_WR
    } state_t;

    logic rise_c;
    logic mdio_q;

    mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .mdc_i  (mdc_i),
        .mdio_i (mdio_i),
        .rise_c (rise_c),
        .mdio_q (mdio_q)
    );

    state_t                 state, state_d;
    logic [PRE_CNT_W-1:0]   pre_cnt, pre_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [HDR_LAST-1:0]    hdr_q, hdr_q_d;
    logic [15:0]            shreg, shreg_d;
    logic [4:0]             phyad_q, phyad_q_d;
    logic                   mdio_o_d, mdio_t_d, reg_wr_en_d, reg_rd_en_d, busy_d, frame_error_d;
    logic [4:0]             reg_addr_d;
    logic [15:0]            reg_wr_data_d;
    mdio_hdr_t              hdr_next;
    logic [15:0]            data_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            bit_cnt     <= '0;
            hdr_q       <= '0;
            shreg       <= '0;
            phyad_q     <= '0;
            mdio_o      <= 1'b1;
            mdio_t      <= 1'b1;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_d;
            pre_cnt     <= pre_cnt_d;
            bit_cnt     <= bit_cnt_d;
            hdr_q       <= hdr_q_d;
            shreg       <= shreg_d;
            phyad_q     <= phyad_q_d;
            mdio_o      <= mdio_o_d;
            mdio_t      <= mdio_t_d;
            reg_addr    <= reg_addr_d;
            reg_wr_data <= reg_wr_data_d;
            reg_wr_en   <= reg_wr_en_d;
            reg_rd_en   <= reg_rd_en_d;
            busy        <= busy_d;
            frame_error <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state;
        pre_cnt_d     = pre_cnt;
        bit_cnt_d     = bit_cnt;
        hdr_q_d       = hdr_q;
        shreg_d       = shreg;
        phyad_q_d     = phyad_q;
        mdio_o_d      = mdio_o;
        mdio_t_d      = mdio_t;
        reg_addr_d    = reg_addr;
        reg_wr_data_d = reg_wr_data;
        reg_wr_en_d   = 1'b0;
        reg_rd_en_d   = 1'b0;
        frame_error_d = 1'b0;
        hdr_next      = {hdr_q, mdio_q};
        data_next     = {shreg[14:0], mdio_q};

        if (rise_c) begin
            case (state)
                S_IDLE: begin
                    if (mdio_q) begin
                        if (pre_cnt != PRE_CNT_W'(MDIO_PREAMBLE_LEN)) pre_cnt_d = pre_cnt + 6'd1;
                    end else if (pre_cnt >= PRE_CNT_W'(PRE_MIN)) begin
                        state_d   = S_ST1;
                        phyad_q_d = phy_addr;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                S_ST1: begin
                    bit_cnt_d = '0;
                    if (mdio_q == MDIO_ST[0]) begin
                        state_d = S_HDR;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
                S_HDR: begin
                    hdr_q_d   = hdr_next[HDR_LAST-1:0];
                    bit_cnt_d = bit_cnt + 5'd1;
                    if (bit_cnt == BIT_CNT_W'(HDR_LAST)) begin
                        bit_cnt_d = '0;
                        // foreign PHYAD drops out silently, before any opcode handling
                        if (hdr_next.phyad != phyad_q) begin
                            state_d = S_IDLE;
                        end else if (hdr_next.op == MDIO_OP_ADDR) begin
                            frame_error_d = 1'b1;
                            state_d       = S_IDLE;
                        end else if (hdr_next.op == MDIO_OP_WRITE) begin
                            reg_addr_d = hdr_next.regad;
                            state_d    = S_TA_WR;
                        end else begin
                            reg_addr_d  = hdr_next.regad;
                            reg_rd_en_d = 1'b1;
                            state_d     = S_TA_RD;
                        end
                    end
                end
                S_TA_RD: begin
                    shreg_d   = reg_rd_data;
                    mdio_t_d  = 1'b0;
                    mdio_o_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_RD;
                end
                S_RD: begin
                    if (bit_cnt == BIT_CNT_W'(RD_END)) begin
                        mdio_t_d = 1'b1;
                        mdio_o_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        mdio_o_d  = shreg[15];
                        shreg_d   = {shreg[14:0], 1'b0};
                        bit_cnt_d = bit_cnt + 5'd1;
                    end
                end
                S_TA_WR: begin
                    if (mdio_q != (bit_cnt == '0 ? MDIO_TA_WR[1] : MDIO_TA_WR[0])) begin
                        frame_error_d = 1'b1;
                        state_d       = S_IDLE;
                    end else if (bit_cnt == '0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_WR;
                    end
                end
                S_WR: begin
                    shreg_d   = data_next;
                    bit_cnt_d = bit_cnt + 5'd1;
                    if (bit_cnt == BIT_CNT_W'(DATA_LAST)) begin
                        reg_wr_en_d   = 1'b1;
                        reg_wr_data_d = data_next;
                        state_d       = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // preamble must be rebuilt from zero after every frame or abort
        if (state_d != S_IDLE) pre_cnt_d = '0;
        busy_d = (state_d != S_IDLE);
    end

endmodule
